// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-ported Memory: CPU data port and display refresh.
// One registered transaction at a time, round-robin with a display urgent override.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting; arbitrate and latch the winner onto the mem_* pins
// ST_ISSUE   | mem_* presented to Memory; read data captured at end of cycle
// ST_RESP    | winner's ack is high; strobes are low; back to idle next
module mem_port_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic              vid_urgent,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_isWrite,
    output logic              mem_byteWrite,
    output logic              mem_byteRead,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic [CNT_W-1:0]  contention_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_vid_q, last_vid_d;
    logic              owner_vid_q, owner_vid_d;
    logic              is_write_q, is_write_d;
    logic              byte_write_q, byte_write_d;
    logic              byte_read_q, byte_read_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              vid_ack_q, vid_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pick_vid;

    // On a tie the display wins if urgent or if the CPU had the last grant.
    assign pick_vid = vid_req && (!cpu_req || vid_urgent || !last_vid_q);

    always_comb begin
        state_d      = state_q;
        last_vid_d   = last_vid_q;
        owner_vid_d  = owner_vid_q;
        is_write_d   = is_write_q;
        byte_write_d = byte_write_q;
        byte_read_d  = byte_read_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        cpu_ack_d    = 1'b0;
        vid_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        vid_rdata_d  = vid_rdata_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && vid_req && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cpu_req || vid_req) begin
                    state_d     = ST_ISSUE;
                    owner_vid_d = pick_vid;
                    last_vid_d  = pick_vid;
                    if (pick_vid) begin
                        address_d    = vid_addr;
                        is_write_d   = 1'b0;
                        byte_write_d = 1'b0;
                        byte_read_d  = 1'b0;
                    end else begin
                        address_d    = cpu_addr;
                        write_data_d = cpu_wdata;
                        is_write_d   = cpu_we;
                        byte_write_d = cpu_we && cpu_byte;
                        byte_read_d  = !cpu_we && cpu_byte;
                    end
                end
            end
            ST_ISSUE: begin
                state_d      = ST_RESP;
                is_write_d   = 1'b0;
                byte_write_d = 1'b0;
                byte_read_d  = 1'b0;
                if (owner_vid_q) begin
                    vid_ack_d   = 1'b1;
                    vid_rdata_d = mem_data;
                end else begin
                    cpu_ack_d = 1'b1;
                    if (!is_write_q) begin
                        cpu_rdata_d = mem_data;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_vid_q   <= 1'b1;
            owner_vid_q  <= 1'b0;
            is_write_q   <= 1'b0;
            byte_write_q <= 1'b0;
            byte_read_q  <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            cpu_ack_q    <= 1'b0;
            vid_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            vid_rdata_q  <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_vid_q   <= last_vid_d;
            owner_vid_q  <= owner_vid_d;
            is_write_q   <= is_write_d;
            byte_write_q <= byte_write_d;
            byte_read_q  <= byte_read_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            cpu_ack_q    <= cpu_ack_d;
            vid_ack_q    <= vid_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_rdata_q  <= vid_rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cpu_ack        = cpu_ack_q;
    assign vid_ack        = vid_ack_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign vid_rdata      = vid_rdata_q;
    assign mem_isWrite    = is_write_q;
    assign mem_byteWrite  = byte_write_q;
    assign mem_byteRead   = byte_read_q;
    assign mem_address    = address_q;
    assign mem_writeData  = write_data_q;
    assign busy           = (state_q != ST_IDLE);
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small Memory model; a second
// instance with a 4-bit contention counter shares the stimulus for saturation.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_byte = 1'b0;
    logic [17:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        vid_req = 1'b0, vid_urgent = 1'b0;
    logic [17:0] vid_addr = '0;
    logic [31:0] mem_data = '0;

    logic        cpu_ack, vid_ack, mem_isWrite, mem_byteWrite, mem_byteRead, busy;
    logic [31:0] cpu_rdata, vid_rdata, mem_writeData;
    logic [17:0] mem_address;
    logic [15:0] contention_cnt;

    logic        s_cpu_ack, s_vid_ack, s_iw, s_bw, s_br, s_busy;
    logic [31:0] s_cpu_rdata, s_vid_rdata, s_wd;
    logic [17:0] s_addr;
    logic [3:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_arr [0:(1<<18)-1];

    always #5 clock = ~clock;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_urgent(vid_urgent), .vid_addr(vid_addr),
        .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .mem_isWrite(mem_isWrite), .mem_byteWrite(mem_byteWrite),
        .mem_byteRead(mem_byteRead), .mem_address(mem_address),
        .mem_writeData(mem_writeData), .mem_data(mem_data),
        .busy(busy), .contention_cnt(contention_cnt)
    );

    mem_port_arbiter #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(s_cpu_ack), .cpu_rdata(s_cpu_rdata),
        .vid_req(vid_req), .vid_urgent(vid_urgent), .vid_addr(vid_addr),
        .vid_ack(s_vid_ack), .vid_rdata(s_vid_rdata),
        .mem_isWrite(s_iw), .mem_byteWrite(s_bw),
        .mem_byteRead(s_br), .mem_address(s_addr),
        .mem_writeData(s_wd), .mem_data(mem_data),
        .busy(s_busy), .contention_cnt(s_cnt)
    );

    // Memory samples the registered pins mid-cycle, so read data is ready by the next rising edge.
    always @(negedge clock) begin
        if (mem_isWrite || mem_byteWrite) begin
            if (mem_byteWrite) mem_arr[mem_address][7:0] = mem_writeData[7:0];
            else               mem_arr[mem_address]      = mem_writeData;
        end
        if (mem_byteRead) mem_data = {24'h0, mem_arr[mem_address][7:0]};
        else              mem_data = mem_arr[mem_address];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_access(input logic we, input logic byt, input logic [17:0] a,
                              input logic [31:0] wd, output int lat, output int n_iw,
                              output int n_bw, output int n_br);
        cpu_we = we; cpu_byte = byt; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        lat = 1; n_iw = 0; n_bw = 0; n_br = 0;
        while (!cpu_ack && lat < 20) begin
            @(negedge clock);
            lat++;
            if (mem_isWrite)   n_iw++;
            if (mem_byteWrite) n_bw++;
            if (mem_byteRead)  n_br++;
        end
        cpu_req = 1'b0;
    endtask

    int lat, n_iw, n_bw, n_br, budget, nack;
    logic grants [$];

    initial begin
        mem_arr[18'h00040] = 32'hCAFEF00D;
        mem_arr[18'h00100] = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_acks", {cpu_ack, vid_ack}, 0);
        chk("rst_strobes", {mem_isWrite, mem_byteWrite, mem_byteRead}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_cnt", contention_cnt, 0);
        @(negedge clock);

        // word write then read back
        cpu_access(1, 0, 18'h02368, 32'h12345678, lat, n_iw, n_bw, n_br);
        chk("wr_ack_lat", lat, 3);
        chk("wr_iswrite_cycles", n_iw, 1);
        @(negedge clock);
        chk("wr_ack_pulse", cpu_ack, 0);
        cpu_access(0, 0, 18'h02368, 32'h0, lat, n_iw, n_bw, n_br);
        chk("rd_ack_lat", lat, 3);
        chk("rd_data", cpu_rdata, 32'h12345678);
        chk("rd_no_write", n_iw + n_bw + n_br, 0);
        @(negedge clock);

        // byte write and zero-extended byte read
        cpu_access(1, 1, 18'h02368, 32'h87654321, lat, n_iw, n_bw, n_br);
        chk("bw_strobe", n_bw, 1);
        chk("bw_rdata_held", cpu_rdata, 32'h12345678);
        @(negedge clock);
        cpu_access(0, 1, 18'h02368, 32'h0, lat, n_iw, n_bw, n_br);
        chk("br_strobe", n_br, 1);
        chk("br_data", cpu_rdata, 32'h00000021);
        @(negedge clock);

        // display alone; its grant becomes last_grant
        vid_addr = 18'h00040; vid_req = 1'b1; lat = 1;
        while (!vid_ack && lat < 20) begin
            @(negedge clock); lat++;
            if (lat == 2) chk("vid_strobes", {mem_isWrite, mem_byteWrite, mem_byteRead}, 0);
        end
        vid_req = 1'b0;
        chk("vid_lat", lat, 3);
        chk("vid_data", vid_rdata, 32'hCAFEF00D);
        @(negedge clock);

        // round-robin with both held
        cpu_we = 0; cpu_byte = 0; cpu_addr = 18'h02368;
        cpu_req = 1; vid_req = 1; vid_urgent = 0;
        grants.delete(); budget = 0;
        while (grants.size() < 4 && budget < 60) begin
            @(negedge clock); budget++;
            if (cpu_ack) grants.push_back(1'b0);
            if (vid_ack) grants.push_back(1'b1);
        end
        cpu_req = 0; vid_req = 0;
        chk("rr_count", grants.size(), 4);
        chk("rr_seq", {grants[0], grants[1], grants[2], grants[3]}, 4'b0101);
        chk("rr_cnt", contention_cnt, 4);
        chk("rr_cpu_data", cpu_rdata, 32'h12345621);
        chk("rr_vid_data", vid_rdata, 32'hCAFEF00D);
        @(negedge clock);

        // urgent override after a CPU grant
        cpu_access(0, 0, 18'h02368, 32'h0, lat, n_iw, n_bw, n_br);
        @(negedge clock);
        cpu_req = 1; vid_req = 1; vid_urgent = 1;
        grants.delete(); budget = 0;
        while (grants.size() < 4 && budget < 60) begin
            @(negedge clock); budget++;
            if (cpu_ack) grants.push_back(1'b0);
            if (vid_ack) begin
                grants.push_back(1'b1);
                if (grants.size() == 3) vid_req = 0;
            end
        end
        cpu_req = 0; vid_urgent = 0;
        chk("urg_count", grants.size(), 4);
        chk("urg_seq", {grants[0], grants[1], grants[2], grants[3]}, 4'b1110);
        @(negedge clock);

        // reset during ISSUE of a CPU write, then re-served
        cpu_we = 1; cpu_byte = 0; cpu_addr = 18'h00100; cpu_wdata = 32'hA5A5A5A5; cpu_req = 1;
        @(negedge clock);
        chk("pre_rst_issue", {busy, mem_isWrite}, 2'b11);
        reset = 1'b1;
        #1;
        chk("mid_rst_strobes", {mem_isWrite, mem_byteWrite, mem_byteRead, cpu_ack, vid_ack}, 0);
        chk("mid_rst_addr", mem_address, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdata", {cpu_rdata, vid_rdata}, 0);
        chk("mid_rst_cnt", contention_cnt, 0);
        @(negedge clock);
        reset = 1'b0;
        lat = 1;
        while (!cpu_ack && lat < 20) begin
            @(negedge clock); lat++;
        end
        cpu_req = 0;
        chk("post_rst_lat", lat, 3);
        chk("post_rst_mem", mem_arr[18'h00100], 32'hA5A5A5A5);
        @(negedge clock);

        // contention saturation on the 4-bit instance
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cpu_we = 0; cpu_addr = 18'h02368; cpu_req = 1; vid_req = 1;
        nack = 0; budget = 0;
        while (nack < 21 && budget < 200) begin
            @(negedge clock); budget++;
            if (cpu_ack || vid_ack) begin
                nack++;
                if (nack == 15) chk("sat_cnt4_at15", s_cnt, 4'hE + 4'h1);
            end
        end
        cpu_req = 0; vid_req = 0;
        chk("sat_acks", nack, 21);
        chk("sat_cnt4", s_cnt, 4'hF);
        chk("sat_cnt16", contention_cnt, 21);
        repeat (4) @(negedge clock);
        chk("sat_cnt4_hold", s_cnt, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
